// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce state encoding and default sizing for the button conditioner.
package btn_pkg;
  typedef enum logic [1:0] {ST_LO, WAIT_HI, ST_HI, WAIT_LO} db_state_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int N_BTN_DEFAULT = 5;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button's 2-flop synchroniser, debounce FSM and stable-cycle counter.
// Ports: clk/rst_n (async active-low), btn raw input; level debounced value,
// press/rel one-cycle edge pulses, press_next is the value press takes on the next edge.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic press_next
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2;
  logic [CNT_W-1:0] cnt;
  db_state_t state;
  // Lets the parent register its command strobe on the same edge as press.
  assign press_next = (state == WAIT_HI) && sync2 && (cnt == LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_LO;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        ST_LO:
          if (sync2) begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
          end
        WAIT_HI:
          if (!sync2) begin
            state <= ST_LO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ST_HI;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else cnt <= cnt + 1'b1;
        ST_HI:
          if (!sync2) begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
          end
        WAIT_LO:
          if (sync2) begin
            state <= ST_HI;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= ST_LO;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else cnt <= cnt + 1'b1;
      endcase
    end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounces N_BTN raw buttons and emits one prioritised command strobe per press.
// Ports: CLK, RST_N (async active-low), BTN raw inputs; BTN_LEVEL/BTN_PRESS/BTN_RELEASE per button,
// CMD_VALID pulses with any press, CMD_IDX is the lowest pressed index during CMD_VALID.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES),
  localparam int IDX_W = $clog2(N_BTN)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] BTN,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic             CMD_VALID,
  output logic [IDX_W-1:0] CMD_IDX
);
  logic [N_BTN-1:0] press_next;
  logic [IDX_W-1:0] idx_next;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(CLK),
      .rst_n(RST_N),
      .btn(BTN[i]),
      .level(BTN_LEVEL[i]),
      .press(BTN_PRESS[i]),
      .rel(BTN_RELEASE[i]),
      .press_next(press_next[i])
    );
  end
  // Scanning downward leaves the lowest set index as the final winner.
  always_comb begin
    idx_next = '0;
    for (int i = N_BTN - 1; i >= 0; i--) idx_next = press_next[i] ? IDX_W'(i) : idx_next;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      CMD_VALID <= 1'b0;
      CMD_IDX   <= '0;
    end else begin
      CMD_VALID <= |press_next;
      CMD_IDX   <= idx_next;
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed self-checking bench for btn_conditioner with a short debounce window.
module tb_btn_conditioner;
  logic       CLK = 1'b0;
  logic       RST_N;
  logic [4:0] BTN;
  logic [4:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE;
  logic       CMD_VALID;
  logic [2:0] CMD_IDX;
  int n_tests = 0;
  int n_fail = 0;

  btn_conditioner #(.N_BTN(5), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .BTN(BTN),
    .BTN_LEVEL(BTN_LEVEL),
    .BTN_PRESS(BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE),
    .CMD_VALID(CMD_VALID),
    .CMD_IDX(CMD_IDX)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [31:0] all_out();
    return {13'd0, BTN_LEVEL, BTN_PRESS, BTN_RELEASE, CMD_VALID, CMD_IDX};
  endfunction

  initial begin
    RST_N = 1'b0;
    BTN = 5'b00000;
    tick(2);
    chk("reset_outputs", all_out(), 0);
    tick(3);
    RST_N = 1'b1;
    // clean press of button 0
    BTN = 5'b00001;
    tick(5);
    chk("clean_early_press", BTN_PRESS, 0);
    chk("clean_early_level", BTN_LEVEL, 0);
    tick(1);
    chk("clean_press", BTN_PRESS, 5'b00001);
    chk("clean_level", BTN_LEVEL, 5'b00001);
    chk("clean_valid", CMD_VALID, 1);
    chk("clean_idx", CMD_IDX, 0);
    chk("clean_no_release", BTN_RELEASE, 0);
    tick(1);
    chk("clean_press_width", BTN_PRESS, 0);
    chk("clean_valid_width", CMD_VALID, 0);
    chk("clean_level_held", BTN_LEVEL, 5'b00001);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("held_no_repulse", {BTN_PRESS, CMD_VALID}, 0);
    end
    BTN = 5'b00000;
    tick(6);
    chk("clean_release", BTN_RELEASE, 5'b00001);
    chk("clean_release_level", BTN_LEVEL, 0);
    chk("release_no_cmd", {BTN_PRESS, CMD_VALID}, 0);
    tick(1);
    chk("clean_release_width", BTN_RELEASE, 0);
    // bouncing button 1
    for (int i = 0; i < 4; i++) begin
      BTN = (i % 2 == 0) ? 5'b00010 : 5'b00000;
      tick(1);
      chk("bounce_quiet", all_out(), 0);
    end
    BTN = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bounce_settle_quiet", all_out(), 0);
    end
    tick(1);
    chk("bounce_press", BTN_PRESS, 5'b00010);
    chk("bounce_idx", CMD_IDX, 1);
    chk("bounce_valid", CMD_VALID, 1);
    chk("bounce_level", BTN_LEVEL, 5'b00010);
    BTN = 5'b00000;
    tick(7);
    chk("bounce_released", {BTN_LEVEL, BTN_RELEASE}, 0);
    // glitch on button 2 shorter than the window
    for (int i = 0; i < 13; i++) begin
      BTN = (i < 3) ? 5'b00100 : 5'b00000;
      tick(1);
      chk("glitch_quiet", all_out(), 0);
    end
    // simultaneous press and release
    BTN = 5'b10110;
    tick(5);
    chk("simul_early", BTN_PRESS, 0);
    tick(1);
    chk("simul_press", BTN_PRESS, 5'b10110);
    chk("simul_valid", CMD_VALID, 1);
    chk("simul_idx", CMD_IDX, 1);
    chk("simul_level", BTN_LEVEL, 5'b10110);
    tick(1);
    chk("simul_single_cmd", {BTN_PRESS, CMD_VALID}, 0);
    BTN = 5'b00000;
    tick(6);
    chk("simul_release", BTN_RELEASE, 5'b10110);
    chk("simul_release_valid", CMD_VALID, 0);
    chk("simul_release_level", BTN_LEVEL, 0);
    tick(1);
    // asynchronous reset while a level is held; button stays held through it
    BTN = 5'b00100;
    tick(7);
    chk("held_level_before_rst", BTN_LEVEL, 5'b00100);
    #5 RST_N = 1'b0;
    #2 chk("async_rst_clears", all_out(), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(5);
    chk("post_rst_early", all_out(), 0);
    tick(1);
    chk("post_rst_press", BTN_PRESS, 5'b00100);
    chk("post_rst_idx", CMD_IDX, 2);
    chk("post_rst_valid", CMD_VALID, 1);
    BTN = 5'b00000;
    tick(8);
    // reset in the middle of a count restarts it
    BTN = 5'b00001;
    tick(2);
    RST_N = 1'b0;
    #1 chk("midcount_rst", all_out(), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("midcount_restart_quiet", all_out(), 0);
    end
    tick(1);
    chk("midcount_press", BTN_PRESS, 5'b00001);
    chk("midcount_valid", CMD_VALID, 1);
    chk("midcount_idx", CMD_IDX, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning stage between the Basys board push-buttons and the button-driven memory/datapath blocks. Synchronises and debounces each raw `BTN` input and produces a clean debounced level plus one-cycle press and release pulses per button. It also produces a single prioritised command strobe, so downstream logic performs exactly one write or read per physical button press instead of acting on a held level.

## Interface
- `N_BTN`, 5: number of buttons.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a new level (10 ms at 100 MHz). Minimum 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: counter width. Derived; never overridden.
- `IDX_W`, `$clog2(N_BTN)`: command index width. Derived.

- `CLK`, input, 1: system clock. All logic is on the rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `BTN`, input, `N_BTN`: raw, asynchronous, bouncing button inputs.
- `BTN_LEVEL`, output, `N_BTN`: debounced level.
- `BTN_PRESS`, output, `N_BTN`: one-cycle pulse on each debounced 0→1 transition.
- `BTN_RELEASE`, output, `N_BTN`: one-cycle pulse on each debounced 1→0 transition.
- `CMD_VALID`, output, 1: one-cycle pulse whenever any `BTN_PRESS` bit is set.
- `CMD_IDX`, output, `IDX_W`: index of the lowest-numbered set `BTN_PRESS` bit. Valid only when `CMD_VALID` is high.

## Operation
- Per button, a 2-flop synchroniser (`sync1`, `sync2`) feeds an independent debounce FSM with a `CNT_W`-bit counter.
- FSM states and transitions:
  - `ST_LO`: counter is 0. `sync2`=1 → `WAIT_HI` with counter=1.
  - `WAIT_HI`: `sync2`=0 → `ST_LO`, counter cleared. `sync2`=1 and counter==`DEBOUNCE_CYCLES`-1 → `ST_HI`, `BTN_LEVEL`←1, `BTN_PRESS` pulses. Otherwise counter increments.
  - `ST_HI` and `WAIT_LO`: mirror images of the above. Accepting the new level sets `BTN_LEVEL`←0 and pulses `BTN_RELEASE`.
- Any bounce during a `WAIT_*` state returns the FSM to the prior stable state and fully restarts the count. There is no partial credit.
- `BTN_LEVEL` is set/cleared on the same clock edge that fires the corresponding pulse.
- `CMD_VALID` = OR of `BTN_PRESS`. `CMD_IDX` is a priority encode of `BTN_PRESS`, with the lowest index winning. Both are registered, aligned with `BTN_PRESS`.
- Simultaneous presses on multiple buttons:
  - All matching `BTN_PRESS` bits pulse.
  - `CMD_IDX` reports only the lowest index.
  - No command is queued for the others.
- Releases never generate `CMD_VALID`.
- Counter never exceeds `DEBOUNCE_CYCLES`-1. No wrap-around is possible.
- Reset, asserted asynchronously at any time including mid-count:
  - All synchronisers, counters and outputs go to 0.
  - All FSMs go to `ST_LO`.
- A button held through reset deassertion is treated as a fresh press and is reported after the full latency.

## Timing
- Reset values: `BTN_LEVEL`=0, `BTN_PRESS`=0, `BTN_RELEASE`=0, `CMD_VALID`=0, `CMD_IDX`=0.
- Latency:
  - Edge E is the first rising edge at which a new, thereafter stable `BTN` value is sampled into `sync1`.
  - `BTN_LEVEL` changes, and the pulse and `CMD_VALID` are high, in the cycle following edge E+`DEBOUNCE_CYCLES`+1.
  - That is, `DEBOUNCE_CYCLES`+2 edges inclusive of E.
- Pulse width is exactly 1 cycle. A held button never re-pulses.
- Minimum detectable press: `DEBOUNCE_CYCLES` stable synchronised cycles. Anything shorter is filtered with no output activity.
- Back-to-back events on one button are at least `DEBOUNCE_CYCLES` cycles apart by construction.

## Structure
- Package `btn_pkg`:
  - debounce state enum (`ST_LO`, `WAIT_HI`, `ST_HI`, `WAIT_LO`);
  - `DEFAULT_DEBOUNCE_CYCLES` = 1000000;
  - `N_BTN_DEFAULT` = 5.
- Sub-module `btn_debounce`: a single-bit synchroniser, FSM and counter, with outputs `level`, `press`, `release`. Instantiated `N_BTN` times via generate.
- The top level holds only the generate loop and the registered priority encoder.

## Test plan
Bench overrides `DEBOUNCE_CYCLES`=4, 20 ns clock, reset low for 100 ns.
- Clean press: `BTN`=5'b00001 held after reset → `BTN_LEVEL`[0] rises 6 edges after first sample; `BTN_PRESS`=5'b00001, `CMD_VALID`=1, `CMD_IDX`=0 for exactly one cycle; no further pulses while held.
- Bounce: `BTN`[1] toggles 1,0,1,0 on successive cycles, then holds 1 → no output until 6 edges after the final 0→1 sample; then `BTN_PRESS`=5'b00010, `CMD_IDX`=1.
- Glitch: `BTN`[2] high for 3 cycles, then low → all outputs remain 0 throughout.
- Simultaneous: `BTN`=5'b10110 in one cycle → `BTN_PRESS`=5'b10110 in one cycle, `CMD_VALID`=1, `CMD_IDX`=1; release of all → `BTN_RELEASE`=5'b10110, `CMD_VALID`=0.
- Reset mid-count: `BTN`[0] held, `RST_N` pulsed low 2 edges after first sample → outputs 0 immediately; `BTN_PRESS`[0] fires 6 edges after the first post-reset sample.
